// File: rtl/fb_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fb_wr_arbiter
//  Purpose  : Write-port scheduler for the double-buffered frame-buffer RAM
//             wrapper. The PPU pixel stream always wins. Overlay writes are
//             queued in a small FIFO and drain on idle cycles. End of frame
//             flushes the FIFO before the buffer-swap pulse is issued.
//  Options  : FB_WR_ARB_STATS_EN adds the drop_cnt and frame_cnt outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module fb_wr_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 6,
    parameter int FB_WORDS      = 61440,
    parameter int FIFO_DEPTH    = 4,
    parameter int FLUSH_TIMEOUT = 1024
) (
    input  logic              ppu_clock,
    input  logic              rst_n,
    input  logic              pix_wr,
    input  logic [ADDR_W-1:0] pix_addr,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              ovl_valid,
    output logic              ovl_ready,
    input  logic [ADDR_W-1:0] ovl_addr,
    input  logic [DATA_W-1:0] ovl_data,
    input  logic              frame_end_in,
    output logic              wr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] data,
    output logic              ppu_frame_end,
    output logic              busy,
`ifdef FB_WR_ARB_STATS_EN
    output logic [15:0]       drop_cnt,
    output logic [15:0]       frame_cnt,
`endif
    output logic              flush_err
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int TMR_W  = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam int ENT_W  = ADDR_W + DATA_W;
    localparam int AW1    = ADDR_W + 1;

    localparam logic [AW1-1:0]   FB_LIMIT  = AW1'(FB_WORDS);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(FLUSH_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               flush_err_q, flush_err_d;
    logic               busy_q;
    logic               frame_end_q;
    logic               ovl_ready_q;

    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               wr_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [DATA_W-1:0]  data_q;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    logic               w_pix_legal;
    logic               w_pix_drop;
    logic               w_ovl_legal;
    logic               w_ovl_hs;
    logic               w_ovl_drop;
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_empty;
    logic               w_timeout;
    logic [CNT_W-1:0]   w_discard;
    logic [ENT_W-1:0]   w_head;

    assign w_pix_legal  = pix_wr && ({1'b0, pix_addr} < FB_LIMIT);
    assign w_pix_drop   = pix_wr && !w_pix_legal;
    assign w_ovl_legal  = ({1'b0, ovl_addr} < FB_LIMIT);
    // Handshake uses the registered ready so an accepted request is never lost.
    assign w_ovl_hs     = ovl_valid && ovl_ready_q;
    assign w_ovl_drop   = w_ovl_hs && !w_ovl_legal;
    assign w_push       = w_ovl_hs && w_ovl_legal;
    assign w_fifo_empty = (count_q == '0);
    // An illegal pixel write leaves the cycle free for the overlay queue.
    assign w_pop        = !w_pix_legal && !w_fifo_empty;
    assign w_timeout    = (state_q == ST_FLUSH) && !w_fifo_empty && (timer_q == TMR_LAST);
    // Entries still queued after this cycle's pop are thrown away on timeout.
    assign w_discard    = w_timeout ? (count_q - CNT_W'(w_pop)) : '0;
    assign w_head       = mem_q[rd_ptr_q];

    // FIFO pointer and occupancy next-state; a timeout empties the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_timeout) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // FIFO bookkeeping registers.
    always_ff @(posedge ppu_clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge ppu_clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {ovl_addr, ovl_data};
        end
    end

    // Frame-end sequencing: RUN -> FLUSH (drain) -> SWAP (one cycle) -> RUN.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        flush_err_d = flush_err_q;
        case (state_q)
            ST_RUN: begin
                if (frame_end_in) begin
                    state_d = ST_FLUSH;
                    timer_d = '0;
                end
            end
            ST_FLUSH: begin
                if (frame_end_in) begin
                    flush_err_d = 1'b1;
                end
                if (w_fifo_empty) begin
                    state_d = ST_SWAP;
                end else if (w_timeout) begin
                    state_d     = ST_SWAP;
                    flush_err_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_SWAP: begin
                if (frame_end_in) begin
                    flush_err_d = 1'b1;
                end
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM registers and all control outputs, derived from the next state.
    always_ff @(posedge ppu_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            timer_q     <= '0;
            flush_err_q <= 1'b0;
            busy_q      <= 1'b0;
            frame_end_q <= 1'b0;
            ovl_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            flush_err_q <= flush_err_d;
            busy_q      <= (state_d != ST_RUN);
            frame_end_q <= (state_d == ST_SWAP);
            ovl_ready_q <= (state_d == ST_RUN) && (count_d != CNT_FULL);
        end
    end

    // Write port: the pixel stream has priority, otherwise the FIFO head.
    always_ff @(posedge ppu_clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            data_q    <= '0;
        end else begin
            wr_q <= w_pix_legal || w_pop;
            if (w_pix_legal) begin
                wr_addr_q <= pix_addr;
                data_q    <= pix_data;
            end else if (w_pop) begin
                wr_addr_q <= w_head[ENT_W-1:DATA_W];
                data_q    <= w_head[DATA_W-1:0];
            end
        end
    end

`ifdef FB_WR_ARB_STATS_EN
    logic [15:0] drop_cnt_q;
    logic [15:0] frame_cnt_q;
    logic [16:0] w_drop_sum;

    assign w_drop_sum = {1'b0, drop_cnt_q} + 17'(w_pix_drop) + 17'(w_ovl_drop) + 17'(w_discard);

    // Saturating drop counter and wrapping frame counter.
    always_ff @(posedge ppu_clock or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            drop_cnt_q <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (state_d == ST_SWAP) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign drop_cnt  = drop_cnt_q;
    assign frame_cnt = frame_cnt_q;
`else
    logic w_stats_unused;
    assign w_stats_unused = ^{w_pix_drop, w_ovl_drop, w_discard};
`endif

    assign ovl_ready     = ovl_ready_q;
    assign wr            = wr_q;
    assign wr_addr       = wr_addr_q;
    assign data          = data_q;
    assign ppu_frame_end = frame_end_q;
    assign busy          = busy_q;
    assign flush_err     = flush_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fb_wr_arbiter
//  Purpose  : Directed bench for fb_wr_arbiter with a write-stream scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fb_wr_arbiter;

    localparam logic [15:0] FB_LIMIT = 16'hF000;

    logic        clk;
    logic        rst_n;
    logic        pix_wr;
    logic [15:0] pix_addr;
    logic [5:0]  pix_data;
    logic        ovl_valid;
    logic        ovl_ready;
    logic [15:0] ovl_addr;
    logic [5:0]  ovl_data;
    logic        frame_end_in;
    logic        wr;
    logic [15:0] wr_addr;
    logic [5:0]  data;
    logic        ppu_frame_end;
    logic        busy;
    logic        flush_err;
`ifdef FB_WR_ARB_STATS_EN
    logic [15:0] drop_cnt;
    logic [15:0] frame_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [21:0] exp_q[$];
    logic [21:0] mdl_fifo[$];

    fb_wr_arbiter #(
        .ADDR_W        (16),
        .DATA_W        (6),
        .FB_WORDS      (61440),
        .FIFO_DEPTH    (4),
        .FLUSH_TIMEOUT (8)
    ) dut (
        .ppu_clock     (clk),
        .rst_n         (rst_n),
        .pix_wr        (pix_wr),
        .pix_addr      (pix_addr),
        .pix_data      (pix_data),
        .ovl_valid     (ovl_valid),
        .ovl_ready     (ovl_ready),
        .ovl_addr      (ovl_addr),
        .ovl_data      (ovl_data),
        .frame_end_in  (frame_end_in),
        .wr            (wr),
        .wr_addr       (wr_addr),
        .data          (data),
        .ppu_frame_end (ppu_frame_end),
        .busy          (busy),
`ifdef FB_WR_ARB_STATS_EN
        .drop_cnt      (drop_cnt),
        .frame_cnt     (frame_cnt),
`endif
        .flush_err     (flush_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every write presented to the RAM wrapper must match the next expected one.
    always @(negedge clk) begin
        if (rst_n && wr) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_wr: observed addr %h data %h expected no write", wr_addr, data);
            end
            if (exp_q.size() != 0) begin
                logic [21:0] e;
                e = exp_q.pop_front();
                checks++;
                assert ({wr_addr, data} === e) else begin
                    errors++;
                    $error("FAIL wr_stream: observed %h/%h expected %h/%h", wr_addr, data, e[21:6], e[5:0]);
                end
            end
        end
    end

    // One clock of stimulus, called at a falling edge; the reference model predicts the next write.
    task automatic tick(input logic pw, input logic [15:0] pa, input logic [5:0] pd,
                        input logic ov, input logic [15:0] oa, input logic [5:0] od,
                        input logic oacc, input logic fe, input logic xpfe, input logic xbusy);
        logic xwr;
        pix_wr       = pw;
        pix_addr     = pa;
        pix_data     = pd;
        ovl_valid    = ov;
        ovl_addr     = oa;
        ovl_data     = od;
        frame_end_in = fe;
        if (ov) check("ovl_ready", {31'd0, ovl_ready}, {31'd0, oacc});
        xwr = 1'b0;
        if (pw && (pa < FB_LIMIT)) begin
            exp_q.push_back({pa, pd});
            xwr = 1'b1;
        end else if (mdl_fifo.size() != 0) begin
            exp_q.push_back(mdl_fifo.pop_front());
            xwr = 1'b1;
        end
        if (ov && oacc && (oa < FB_LIMIT)) mdl_fifo.push_back({oa, od});
        @(negedge clk);
        pix_wr       = 1'b0;
        ovl_valid    = 1'b0;
        frame_end_in = 1'b0;
        check("wr", {31'd0, wr}, {31'd0, xwr});
        check("ppu_frame_end", {31'd0, ppu_frame_end}, {31'd0, xpfe});
        check("busy", {31'd0, busy}, {31'd0, xbusy});
    endtask

    task automatic idle(input logic xpfe, input logic xbusy);
        tick(1'b0, 16'h0, 6'h0, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0, xpfe, xbusy);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr"}, {31'd0, wr}, 32'd0);
        check({tag, "_wr_addr"}, {16'd0, wr_addr}, 32'd0);
        check({tag, "_data"}, {26'd0, data}, 32'd0);
        check({tag, "_frame_end"}, {31'd0, ppu_frame_end}, 32'd0);
        check({tag, "_ovl_ready"}, {31'd0, ovl_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_flush_err"}, {31'd0, flush_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; pix_wr = 1'b0; pix_addr = '0; pix_data = '0;
        ovl_valid = 1'b0; ovl_addr = '0; ovl_data = '0; frame_end_in = 1'b0;

        // Reset state
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(1'b0, 1'b0);

        // Single pixel write
        tick(1'b1, 16'h00A5, 6'h1E, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pix_addr_out", {16'd0, wr_addr}, 32'h00A5);
        check("pix_data_out", {26'd0, data}, 32'h1E);

        // Pixel stream with concurrent overlay pushes until the FIFO is full
        for (int i = 0; i < 10; i++) begin
            if (i < 4)
                tick(1'b1, 16'h0200 + 16'(i), 6'(i), 1'b1, 16'h0100 + 16'(i), 6'h20 + 6'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            else
                tick(1'b1, 16'h0200 + 16'(i), 6'(i), 1'b1, 16'h0104, 6'h24, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) idle(1'b0, 1'b0);

        // Flush of three queued entries, then the swap pulse
        for (int i = 0; i < 3; i++)
            tick(1'b1, 16'h0400 + 16'(i), 6'h01, 1'b1, 16'h0300 + 16'(i), 6'h30 + 6'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 16'h0, 6'h0, 1'b0, 16'h0, 6'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 16'h0, 6'h0, 1'b1, 16'h03FF, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b0);

        // Out-of-range addresses on both ports, and the range boundary
        tick(1'b1, 16'hF000, 6'h05, 1'b1, 16'hFFFF, 6'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 16'h0, 6'h0, 1'b1, 16'h0600, 6'h08, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 16'h0700, 6'h09, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 16'hF001, 6'h0B, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 16'hEFFF, 6'h0A, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
`ifdef FB_WR_ARB_STATS_EN
        check("drop_cnt_range", {16'd0, drop_cnt}, 32'd3);
`endif

        // Second frame_end during FLUSH: error flag, still exactly one swap pulse
        tick(1'b1, 16'h0800, 6'h11, 1'b1, 16'h0900, 6'h21, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 16'h0801, 6'h12, 1'b1, 16'h0901, 6'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 16'h0802, 6'h13, 1'b0, 16'h0, 6'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("flush_err_before", {31'd0, flush_err}, 32'd0);
        tick(1'b1, 16'h0803, 6'h14, 1'b0, 16'h0, 6'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("flush_err_double_fe", {31'd0, flush_err}, 32'd1);
        tick(1'b0, 16'h0, 6'h0, 1'b1, 16'h09FF, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b0);

        // Asynchronous reset in the middle of a FLUSH
        tick(1'b1, 16'h0810, 6'h15, 1'b1, 16'h0910, 6'h25, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 16'h0811, 6'h16, 1'b0, 16'h0, 6'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 16'h0812, 6'h17, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        check("sb_empty_at_reset", exp_q.size(), 32'd0);
        mdl_fifo.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);

        // Flush timeout with the pixel stream holding the write port
        for (int i = 0; i < 4; i++)
            tick(1'b1, 16'h0A00 + 16'(i), 6'h02, 1'b1, 16'h0B00 + 16'(i), 6'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 16'h0A04, 6'h03, 1'b0, 16'h0, 6'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++)
            tick(1'b1, 16'h0A10 + 16'(i), 6'h04, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("flush_err_pre_timeout", {31'd0, flush_err}, 32'd0);
        tick(1'b1, 16'h0A20, 6'h05, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        mdl_fifo.delete();
        check("flush_err_timeout", {31'd0, flush_err}, 32'd1);
`ifdef FB_WR_ARB_STATS_EN
        check("drop_cnt_timeout", {16'd0, drop_cnt}, 32'd4);
        check("frame_cnt", {16'd0, frame_cnt}, 32'd1);
`endif
        tick(1'b1, 16'h0A21, 6'h06, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
